// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: memory op encodings, FSM states
// and the request legality check used at accept time.
package mem_access_unit_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RMW  = 2'd1,
        ST_RESP = 2'd2
    } mau_state_e;

    // Unsigned variants only make sense for loads; stores reject them.
    function automatic logic req_is_err(input logic store, input logic [2:0] op,
                                        input logic [1:0] offset);
        logic err;
        err = 1'b0;
        case (op)
            MEMOP_B:  err = 1'b0;
            MEMOP_H:  err = offset[0];
            MEMOP_W:  err = (offset != 2'b00);
            MEMOP_BU: err = store;
            MEMOP_HU: err = store | offset[0];
            default:  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane handling: extracts/extends load data from a memory word and
// merges sub-word store data into an old word (little-endian lanes).
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] load_word,
    input  logic [1:0]  load_offset,
    input  logic [2:0]  load_op,
    output logic [31:0] load_result,
    input  logic [31:0] store_old,
    input  logic [31:0] store_data,
    input  logic [1:0]  store_offset,
    input  logic [2:0]  store_op,
    output logic [31:0] store_merged
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        load_byte   = load_word[{load_offset, 3'b000} +: 8];
        load_half   = load_offset[1] ? load_word[31:16] : load_word[15:0];
        load_result = 32'd0;
        case (load_op)
            MEMOP_B:  load_result = {{24{load_byte[7]}}, load_byte};
            MEMOP_BU: load_result = {24'd0, load_byte};
            MEMOP_H:  load_result = {{16{load_half[15]}}, load_half};
            MEMOP_HU: load_result = {16'd0, load_half};
            MEMOP_W:  load_result = load_word;
            default:  load_result = 32'd0;
        endcase
    end

    always_comb begin
        store_merged = store_old;
        case (store_op)
            MEMOP_B: store_merged[{store_offset, 3'b000} +: 8] = store_data[7:0];
            MEMOP_H: begin
                if (store_offset[1]) begin
                    store_merged[31:16] = store_data[15:0];
                end else begin
                    store_merged[15:0] = store_data[15:0];
                end
            end
            MEMOP_W: store_merged = store_data;
            default: store_merged = store_old;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and data_memory: one request at a time,
// sub-word stores done as a read-modify-write, registered response with error flag.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DM_AW = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic [DM_AW-1:0] dm_address,
    output logic             dm_wen,
    output logic [31:0]      dm_write_data,
    input  logic [31:0]      dm_read_data
);

    mau_state_e        state_q, state_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [DM_AW-1:0]  addr_q, addr_d;
    logic [1:0]        offset_q, offset_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       old_q, old_d;

    logic              accept;
    logic              req_err;
    logic [31:0]       load_result;
    logic [31:0]       store_merged;
    logic              unused_addr_bits;

    // Address bits above the data_memory range are dropped, so addresses wrap.
    assign unused_addr_bits = ^req_addr[31:DM_AW+2];

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign accept     = req_valid & req_ready;
    assign req_err    = req_is_err(req_store, req_op, req_addr[1:0]);

    mem_lane_align u_lane_align (
        .load_word    (dm_read_data),
        .load_offset  (req_addr[1:0]),
        .load_op      (req_op),
        .load_result  (load_result),
        .store_old    (old_q),
        .store_data   (wdata_q),
        .store_offset (offset_q),
        .store_op     (op_q),
        .store_merged (store_merged)
    );

    always_comb begin
        state_d       = state_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        addr_d        = addr_q;
        offset_d      = offset_q;
        op_d          = op_q;
        wdata_d       = wdata_q;
        old_d         = old_q;
        dm_address    = addr_q;
        dm_wen        = 1'b0;
        dm_write_data = req_wdata;

        case (state_q)
            ST_IDLE: begin
                dm_address = req_addr[DM_AW+1:2];
                if (accept) begin
                    state_d      = ST_RESP;
                    resp_err_d   = req_err;
                    resp_rdata_d = 32'd0;
                    addr_d       = req_addr[DM_AW+1:2];
                    offset_d     = req_addr[1:0];
                    op_d         = req_op;
                    wdata_d      = req_wdata;
                    old_d        = dm_read_data;
                    if (!req_err) begin
                        if (!req_store) begin
                            resp_rdata_d = load_result;
                        end else if (req_op == MEMOP_W) begin
                            dm_wen = 1'b1;
                        end else begin
                            state_d = ST_RMW;
                        end
                    end
                end
            end
            ST_RMW: begin
                dm_wen        = 1'b1;
                dm_write_data = store_merged;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A reset in the RMW cycle must abandon the pending write.
        if (rst) begin
            dm_wen = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            addr_q       <= '0;
            offset_q     <= 2'd0;
            op_q         <= 3'd0;
            wdata_q      <= 32'd0;
            old_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            addr_q       <= addr_d;
            offset_q     <= offset_d;
            op_q         <= op_d;
            wdata_q      <= wdata_d;
            old_q        <= old_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios then random traffic,
// checked against a byte-addressed reference memory kept in the bench.
module tb_mem_access_unit;

    localparam int DM_AW = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_store;
    logic [2:0]       req_op;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic [DM_AW-1:0] dm_address;
    logic             dm_wen;
    logic [31:0]      dm_write_data;
    logic [31:0]      dm_read_data;

    logic [31:0] mem [0:(1<<DM_AW)-1];
    logic [7:0]  ref_bytes [0:4095];
    int          wen_count = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    mem_access_unit #(.DM_AW(DM_AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .dm_address    (dm_address),
        .dm_wen        (dm_wen),
        .dm_write_data (dm_write_data),
        .dm_read_data  (dm_read_data)
    );

    always #5 clk = ~clk;

    // data_memory stand-in: combinational read, write on the rising edge.
    assign dm_read_data = mem[dm_address];

    always @(posedge clk) begin
        if (dm_wen) begin
            mem[dm_address] <= dm_write_data;
            wen_count       <= wen_count + 1;
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [11:0] b;
        b = {a[11:2], 2'b00};
        return {ref_bytes[b + 12'd3], ref_bytes[b + 12'd2], ref_bytes[b + 12'd1], ref_bytes[b]};
    endfunction

    function automatic logic ref_err(input logic st, input logic [2:0] op, input logic [31:0] a);
        if (st && !(op inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        if (!st && !(op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if ((op == 3'd1 || op == 3'd5) && a[0]) return 1'b1;
        if (op == 3'd2 && a[1:0] != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
        logic [11:0] b;
        logic [7:0]  by;
        logic [15:0] hw;
        b  = a[11:0];
        by = ref_bytes[b];
        hw = {ref_bytes[b + 12'd1], ref_bytes[b]};
        case (op)
            3'd0:    return 32'($signed(by));
            3'd4:    return 32'(by);
            3'd1:    return 32'($signed(hw));
            3'd5:    return 32'(hw);
            default: return ref_word(a);
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = (op == 3'd0) ? 1 : (op == 3'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            ref_bytes[a[11:0] + 12'(i)] = d[8*i +: 8];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full transaction, starting and ending just after a rising edge.
    task automatic applyStimulus(input logic st, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] d, input int hold);
        logic        err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_word;
        logic        rmw;
        int          wen_start;

        err       = ref_err(st, op, a);
        exp_rdata = (!st && !err) ? ref_load(op, a) : 32'd0;
        rmw       = st && !err && (op != 3'd2);
        wen_start = wen_count;

        req_valid = 1'b1;
        req_store = st;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        #1;
        checkOutput("accept_ready", 32'(req_ready), 32'd1);
        checkOutput("accept_addr", 32'(dm_address), 32'(a[11:2]));
        checkOutput("accept_wen", 32'(dm_wen), 32'(st && !err && op == 3'd2));
        if (st && !err && op == 3'd2) checkOutput("sw_data", dm_write_data, d);

        @(posedge clk); #1;
        req_valid = 1'b0;
        if (st && !err) ref_store(op, a, d);
        exp_word = ref_word(a);

        if (rmw) begin
            checkOutput("rmw_wen", 32'(dm_wen), 32'd1);
            checkOutput("rmw_data", dm_write_data, exp_word);
            checkOutput("rmw_valid", 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end

        checkOutput("resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("resp_rdata", resp_rdata, exp_rdata);
        checkOutput("resp_err", 32'(resp_err), 32'(err));
        checkOutput("resp_busy", 32'(req_ready), 32'd0);

        // A stray word store offered while busy must not be taken.
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_store = 1'b1;
            req_op    = 3'd2;
            req_addr  = a & 32'hFFFF_FFFC;
            req_wdata = $urandom;
            @(posedge clk); #1;
            checkOutput("hold_valid", 32'(resp_valid), 32'd1);
            checkOutput("hold_rdata", resp_rdata, exp_rdata);
            checkOutput("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid  = 1'b0;

        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput("post_valid", 32'(resp_valid), 32'd0);
        checkOutput("post_ready", 32'(req_ready), 32'd1);
        checkOutput("wen_pulses", 32'(wen_count - wen_start), 32'(st && !err));
        checkOutput("mem_word", mem[a[11:2]], exp_word);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic        st;
        int          sel;

        for (int i = 0; i < (1 << DM_AW); i++) mem[i] = 32'd0;
        for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'd0;

        rst        = 1'b1;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_op     = 3'd2;
        req_addr   = 32'h10;
        req_wdata  = 32'hCAFEF00D;
        resp_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("rst_wen_forced", 32'(dm_wen), 32'd0);
        req_valid = 1'b0;
        rst       = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_rdata", resp_rdata, 32'd0);
        checkOutput("rst_err", 32'(resp_err), 32'd0);
        checkOutput("rst_no_write", 32'(wen_count), 32'd0);
        @(posedge clk); #1;

        $display("[TB] directed loads and stores");
        applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        checkOutput("sw_word4", mem[4], 32'hDEADBEEF);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'd0, 0);
        applyStimulus(1'b0, 3'd0, 32'h13, 32'd0, 0);
        applyStimulus(1'b0, 3'd4, 32'h13, 32'd0, 0);
        applyStimulus(1'b0, 3'd1, 32'h10, 32'd0, 0);
        applyStimulus(1'b0, 3'd5, 32'h12, 32'd0, 0);
        applyStimulus(1'b1, 3'd0, 32'h11, 32'h55, 0);
        checkOutput("sb_word4", mem[4], 32'hDEAD55EF);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'd0, 0);
        applyStimulus(1'b1, 3'd1, 32'h12, 32'h1234, 0);
        checkOutput("sh_word4", mem[4], 32'h123455EF);

        $display("[TB] error requests and backpressure");
        applyStimulus(1'b0, 3'd2, 32'h12, 32'd0, 0);
        applyStimulus(1'b1, 3'd1, 32'h11, 32'hFFFF, 0);
        applyStimulus(1'b1, 3'd4, 32'h10, 32'hAA, 0);
        checkOutput("err_word4", mem[4], 32'h123455EF);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'd0, 5);

        $display("[TB] reset during read-modify-write");
        applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        sel       = wen_count;
        req_valid = 1'b1;
        req_store = 1'b1;
        req_op    = 3'd0;
        req_addr  = 32'h11;
        req_wdata = 32'h55;
        #1;
        checkOutput("rr_accept_wen", 32'(dm_wen), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("rr_rmw_wen", 32'(dm_wen), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rr_wen_killed", 32'(dm_wen), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rr_word4", mem[4], 32'hDEADBEEF);
        checkOutput("rr_no_write", 32'(wen_count - sel), 32'd0);
        checkOutput("rr_valid", 32'(resp_valid), 32'd0);
        checkOutput("rr_ready", 32'(req_ready), 32'd1);

        $display("[TB] random traffic");
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: op = 3'd0; 1: op = 3'd1; 2: op = 3'd4; 3: op = 3'd5;
                4: op = 3'd3; 5: op = 3'd6; 6: op = 3'd7;
                default: op = 3'd2;
            endcase
            st = 1'($urandom_range(0, 1));
            a  = $urandom & 32'hFFFF_F03F;
            if ($urandom_range(0, 3) != 0) begin
                if (op == 3'd1 || op == 3'd5) a[0] = 1'b0;
                if (op == 3'd2) a[1:0] = 2'b00;
            end
            applyStimulus(st, op, a, $urandom, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
